// File: rtl/adc0809_emulator.sv
// Emulates the ADC0809 ALE/START/EOC/OE handshake, taking each channel's level from ch_values.
// Optional feature: define ADC_EMU_NOISE_EN to add +/-1 LSB LFSR dither to each captured sample.
module adc0809_emulator #(
    parameter int EOC_DELAY   = 8,
    parameter int CONV_CYCLES = 64
) (
    input  logic        clk_500khz,
    input  logic        rst_n,
    input  logic        adc_ale,
    input  logic        adc_start,
    input  logic        adc_oe,
    input  logic [2:0]  adc_addr,
    input  logic [63:0] ch_values,
    output logic        adc_eoc,
    output logic [7:0]  adc_data_out,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CONVERT
    } state_t;

    localparam logic [7:0] DELAY_LAST = 8'(EOC_DELAY - 1);
    localparam logic [7:0] CONV_LAST  = 8'(CONV_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ale_q, start_q;
    logic        ale_rise, start_rise, start_fall;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sample_q, sample_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  captured;
    logic [7:0]  ch_level [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign ch_level[gi] = ch_values[8*gi +: 8];
    end

    // ale_q/start_q hold last cycle's pin levels for edge detection
    assign ale_rise   = adc_ale & ~ale_q;
    assign start_rise = adc_start & ~start_q;
    assign start_fall = ~adc_start & start_q;

`ifdef ADC_EMU_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  raw_level;

    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        raw_level = ch_level[addr_q];
        captured  = raw_level;
        if (lfsr_q[1:0] == 2'b00 && raw_level != 8'h00) begin
            captured = raw_level - 8'd1;
        end else if (lfsr_q[1:0] == 2'b11 && raw_level != 8'hFF) begin
            captured = raw_level + 8'd1;
        end
    end

    always_ff @(posedge clk_500khz) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign captured = ch_level[addr_q];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        out_d    = out_q;
        addr_d   = ale_rise ? adc_addr : addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (start_fall) begin
                    state_d = S_DELAY;
                    cnt_d   = 8'd0;
                end
            end
            S_DELAY: begin
                // a new START rise restarts the handshake; the output latch is untouched
                if (start_rise) begin
                    state_d = S_ARMED;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d  = S_CONVERT;
                    cnt_d    = 8'd0;
                    sample_d = captured;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CONVERT: begin
                if (start_rise) begin
                    state_d = S_ARMED;
                end else if (cnt_q == CONV_LAST) begin
                    state_d = S_IDLE;
                    out_d   = sample_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_500khz) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ale_q    <= 1'b0;
            start_q  <= 1'b0;
            addr_q   <= 3'd0;
            cnt_q    <= 8'd0;
            sample_q <= 8'h00;
            out_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            ale_q    <= adc_ale;
            start_q  <= adc_start;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            out_q    <= out_d;
        end
    end

    assign adc_eoc      = (state_q != S_CONVERT);
    assign busy         = (state_q != S_IDLE);
    assign adc_data_out = adc_oe ? out_q : 8'h00;

endmodule

// File: tb/tb_adc0809_emulator.sv
// Bench for adc0809_emulator: a timeline model predicts EOC/busy/data for each conversion.
module tb_adc0809_emulator;
    localparam int EOC_DELAY   = 8;
    localparam int CONV_CYCLES = 64;
`ifdef ADC_EMU_NOISE_EN
    localparam int TOL = 1;
`else
    localparam int TOL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        adc_ale;
    logic        adc_start;
    logic        adc_oe;
    logic [2:0]  adc_addr;
    logic [63:0] ch_values;
    logic        adc_eoc;
    logic [7:0]  adc_data_out;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  m_addr;
    logic [7:0]  m_out;

    adc0809_emulator #(
        .EOC_DELAY  (EOC_DELAY),
        .CONV_CYCLES(CONV_CYCLES)
    ) dut (
        .clk_500khz  (clk),
        .rst_n       (rst_n),
        .adc_ale     (adc_ale),
        .adc_start   (adc_start),
        .adc_oe      (adc_oe),
        .adc_addr    (adc_addr),
        .ch_values   (ch_values),
        .adc_eoc     (adc_eoc),
        .adc_data_out(adc_data_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [7:0] obs, input logic [7:0] exp, input int tol);
        int lo;
        int hi;
        lo = int'(exp) - tol;
        hi = int'(exp) + tol;
        if (lo < 0)   lo = 0;
        if (hi > 255) hi = 255;
        checks++;
        assert ((!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // Tick t is sampled just after the t-th edge counted from the first edge seeing START high.
    // Model: START held n cycles -> EOC low for ticks [n+1+EOC_DELAY, +CONV_CYCLES), busy until done.
    task automatic run_conv(input logic [2:0] addr, input bit use_ale, input int n_hold,
                            input int abort_at, input bit use_mid, input logic [63:0] mid_vals);
        int         fall_t;
        int         rise_t;
        logic [7:0] exp_sample;
        logic [7:0] exp_data;
        if (use_ale) m_addr = addr;
        exp_sample = 8'h00;
        adc_addr  = addr;
        adc_ale   = use_ale;
        adc_start = 1'b1;
        fall_t = n_hold + 1 + EOC_DELAY;
        rise_t = fall_t + CONV_CYCLES;
        for (int t = 1; t <= rise_t; t++) begin
            tick();
            if (t == 1) adc_ale = 1'b0;
            if (t == n_hold) adc_start = 1'b0;
            if (t == fall_t) begin
                exp_sample = ch_values[8*m_addr +: 8];
                if (use_mid) ch_values = mid_vals;
            end
            adc_oe = 1'($urandom_range(0, 1));
            #1;
            check("eoc", 16'(adc_eoc), 16'(!(t >= fall_t && t < rise_t)));
            check("busy", 16'(busy), 16'(t < rise_t));
            exp_data = adc_oe ? ((t >= rise_t) ? exp_sample : m_out) : 8'h00;
            check_near("data", adc_data_out, exp_data, adc_oe ? TOL : 0);
            if (abort_at > 0 && t == fall_t + abort_at) begin
                $display("conv addr=%0d hold=%0d aborted at convert cycle %0d", m_addr, n_hold, abort_at);
                return;
            end
        end
        m_out = exp_sample;
        $display("conv addr=%0d hold=%0d expected=%h observed=%h", m_addr, n_hold, exp_sample, dut.out_q);
    endtask

    initial begin
        logic [7:0] lvl;
        rst_n     = 1'b0;
        adc_ale   = 1'b0;
        adc_start = 1'b0;
        adc_oe    = 1'b0;
        adc_addr  = 3'd0;
        ch_values = 64'h0;
        m_addr    = 3'd0;
        m_out     = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            adc_oe = i[0];
            #1;
            check("rst_eoc", 16'(adc_eoc), 16'h1);
            check("rst_busy", 16'(busy), 16'h0);
            check("rst_data", 16'(adc_data_out), 16'h00);
        end

        // basic conversion of channel 0
        ch_values = 64'h5A;
        run_conv(3'd0, 1'b1, 1, 0, 1'b0, 64'h0);
        adc_oe = 1'b1;
        #1;
        check("oe_hi", 16'(adc_data_out), 16'h5A);
        adc_oe = 1'b0;
        #1;
        check("oe_lo", 16'(adc_data_out), 16'h00);

        // abort 20 cycles into CONVERT, then a fresh conversion with a new level
        run_conv(3'd0, 1'b1, 1, 20, 1'b0, 64'h0);
        ch_values = 64'h77;
        run_conv(3'd0, 1'b1, 1, 0, 1'b0, 64'h0);

        // channel 5 changes after capture; result keeps the captured level
        ch_values = 64'h0000_C300_0000_0000;
        run_conv(3'd5, 1'b1, 2, 0, 1'b1, 64'h0000_1100_0000_0000);

        // reset pulse in the middle of DELAY
        adc_addr  = 3'd5;
        adc_ale   = 1'b1;
        adc_start = 1'b1;
        tick();
        adc_ale   = 1'b0;
        adc_start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        adc_oe = 1'b1;
        #1;
        check("midrst_eoc", 16'(adc_eoc), 16'h1);
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_data", 16'(adc_data_out), 16'h00);
        rst_n  = 1'b1;
        m_out  = 8'h00;
        m_addr = 3'd0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("postrst_eoc", 16'(adc_eoc), 16'h1);
            check("postrst_busy", 16'(busy), 16'h0);
        end
        $display("reset mid-delay: no conversion completed");

        // randomized conversions
        for (int i = 0; i < 30; i++) begin
            ch_values = {$urandom, $urandom};
            run_conv(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                     0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        // rail levels: results must stay near the rails without wrapping
        for (int k = 0; k < 2; k++) begin
            lvl = (k == 0) ? 8'h00 : 8'hFF;
            ch_values = {8{lvl}};
            for (int i = 0; i < 200; i++) begin
                run_conv(3'($urandom_range(0, 7)), 1'b1, 1, 0, 1'b0, 64'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
